mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the RV32I 5-stage pipeline. Sits between the EX-MEM and MEM-WB pipeline registers.
//  Runs the data-memory bus handshake (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n) for loads and stores.
//  Aligns and extends load data, and stalls the pipeline while an access is outstanding.
// PARAMETERS
//  TIMEOUT  255  max cycles in ACCESS waiting for ACKD_n=0 before aborting; 0 = no timeout
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   reset, synchronous, active-low
//  req_valid  in   1   EX-MEM holds a load/store this cycle
//  req_write  in   1   1 = store, 0 = load
//  req_funct3 in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr   in   32  effective address (ALU result)
//  req_wdata  in   32  store data (rs2), right-justified
//  stall      out  1   hold IF..EX-MEM registers
//  done_valid out  1   1-cycle pulse: access finished; load_data valid for MEM-WB
//  load_data  out  32  aligned, sign/zero-extended load result
//  misalign   out  1   1-cycle pulse with done_valid: misaligned access, no bus cycle issued
//  bus_err    out  1   1-cycle pulse with done_valid: timeout abort
//  DAD        out  32  data address bus
//  DDT        inout 32 data bus; driven only during a store ACCESS, else Z
//  MREQ       out  1   memory request
//  WRITE      out  1   1 = write
//  SIZE       out  2   00 word, 01 halfword, 10 byte
//  ACKD_n     in   1   0 = memory completes access this cycle
// BEHAVIOUR
//  - States: IDLE, ACCESS, DONE. Reset (rst_n=0 at edge) -> IDLE from any state, including mid-ACCESS.
//    The bus request is dropped; it is not retried.
//  - Reset/IDLE output values: MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT=Z, done_valid=0, misalign=0,
//    bus_err=0, load_data=0, timeout counter=0.
//  - IDLE: stall = req_valid, combinational.
//    - req_valid, aligned: register addr/write/funct3/wdata; go to ACCESS.
//    - req_valid, misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to DONE with misalign=1.
//      No MREQ is issued.
//  - ACCESS: MREQ=1, DAD=registered addr, WRITE/SIZE from registered request; stall=1.
//    - Store: DDT drives replicated lanes: byte -> {4{b}}, half -> {2{h}}, word -> as-is.
//    - ACKD_n=0 at edge: loads capture DDT; go to DONE.
//    - ACKD_n=1: increment counter. If TIMEOUT!=0 and counter reaches TIMEOUT, go to DONE with bus_err=1.
//  - DONE: stall=0, done_valid=1; load_data, misalign and bus_err are valid. Always go to IDLE next.
//    load_data=0 for stores, misalign and bus_err.
//  - Load lanes are little-endian: byte at addr[1:0]=k is DDT[8k+7:8k]; half at addr[1]=h is DDT[16h+15:16h].
//    LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  - Latency with zero-wait memory: 3 cycles (IDLE accept, ACCESS with ack, DONE). Each wait state adds 1.
//  - ACKD_n is ignored outside ACCESS. req_* inputs are ignored outside IDLE; upstream holds them via stall.
//  - Counter is 8 bits wide minimum (sized to hold TIMEOUT); cleared on entering ACCESS.
// STRUCTURE
//  - Shared constants file rv32i_defs.vh holds: funct3 codes, SIZE encodings, MEM state encodings.
//    IF/ID/EX reuse it.
//  - One sub-module, load_aligner (combinational): {funct3, addr[1:0], raw 32} -> extended 32.
//  - FSM, request registers, timeout counter and DDT tristate stay in mem_access_stage.
// TESTING
//  - LW 0x0000_2000, ACKD_n=0 at once, DDT=0xDEAD_BEEF -> MREQ 1 cycle, SIZE=00, WRITE=0;
//    done_valid next cycle with load_data=0xDEAD_BEEF; stall 2 cycles.
//  - LB addr 0x2003, DDT=0x80xx_xxxx -> load_data=0xFFFF_FF80; LBU same -> 0x0000_0080;
//    LHU addr 0x2002, DDT=0x8001_xxxx -> 0x0000_8001.
//  - SB addr 0x2001 wdata 0x1234_56A5, ACKD_n=1 for 3 cycles then 0 -> MREQ/WRITE=1, SIZE=10,
//    DDT=0xA5A5_A5A5 for 4 cycles, then Z; stall 5 cycles.
//  - LH addr 0x2001 -> no MREQ; done_valid+misalign on cycle 2; load_data=0.
//  - TIMEOUT=4, ACKD_n stuck 1 -> MREQ exactly 4 cycles, then done_valid+bus_err, then IDLE.
//  - rst_n=0 during store ACCESS -> next cycle MREQ=0, DDT=Z, stall=0, no done_valid.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared RV32I memory-stage definitions: funct3 codes, SIZE encodings, FSM states and helpers.
package mem_access_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // Request fields kept after the address/data have been launched onto the bus
    typedef struct packed {
        logic       write;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } mem_ctl_t;

    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (size_of(funct3))
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return |addr_lo;
            default:   return 1'b0;
        endcase
    endfunction

    // Replicate store data so every byte lane carries the operand
    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] funct3,
                                                    input logic [XLEN-1:0] wdata);
        case (size_of(funct3))
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_aligner.sv
// Selects the addressed little-endian lane of a load word and sign/zero-extends it.
module load_aligner
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

        data_c = raw;
        case (funct3)
            F3_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_c = {24'd0, byte_sel};
            F3_H:    data_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_c = {16'd0, half_sel};
            default: data_c = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: data-bus handshake for loads/stores, load alignment and pipeline stall.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            stall,
    output logic            done_valid,
    output logic [XLEN-1:0] load_data,
    output logic            misalign,
    output logic            bus_err,
    output logic [XLEN-1:0] DAD,
    inout  wire  [XLEN-1:0] DDT,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE,
    input  logic            ACKD_n
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    mem_state_e      state;
    mem_ctl_t        ctl;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc_c;
    logic            timeout_hit_c;
    logic            ddt_oe;
    logic [XLEN-1:0] ddt_out;
    logic [XLEN-1:0] aligned_c;

    assign DDT = ddt_oe ? ddt_out : {XLEN{1'bz}};

    assign cnt_inc_c     = cnt + CNT_W'(1);
    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_inc_c == CNT_W'(TIMEOUT));

    load_aligner u_load_aligner (
        .funct3  (ctl.funct3),
        .addr_lo (ctl.addr_lo),
        .raw     (DDT),
        .data_c  (aligned_c)
    );

    // Upstream must hold while a request is being accepted or is on the bus
    always_comb begin
        stall = 1'b0;
        case (state)
            ST_IDLE:   stall = req_valid;
            ST_ACCESS: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ctl        <= '0;
            cnt        <= '0;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= SIZE_WORD;
            DAD        <= '0;
            ddt_oe     <= 1'b0;
            ddt_out    <= '0;
            done_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            load_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (is_misaligned(req_funct3, req_addr[1:0])) begin
                            state      <= ST_DONE;
                            done_valid <= 1'b1;
                            misalign   <= 1'b1;
                            load_data  <= '0;
                        end else begin
                            state   <= ST_ACCESS;
                            ctl     <= '{write: req_write, funct3: req_funct3,
                                         addr_lo: req_addr[1:0]};
                            cnt     <= '0;
                            MREQ    <= 1'b1;
                            WRITE   <= req_write;
                            SIZE    <= size_of(req_funct3);
                            DAD     <= req_addr;
                            ddt_oe  <= req_write;
                            ddt_out <= store_lanes(req_funct3, req_wdata);
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!ACKD_n || timeout_hit_c) begin
                        state      <= ST_DONE;
                        done_valid <= 1'b1;
                        bus_err    <= ACKD_n;
                        load_data  <= (!ACKD_n && !ctl.write) ? aligned_c : '0;
                        cnt        <= '0;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        SIZE       <= SIZE_WORD;
                        DAD        <= '0;
                        ddt_oe     <= 1'b0;
                        ddt_out    <= '0;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    done_valid <= 1'b0;
                    misalign   <= 1'b0;
                    bus_err    <= 1'b0;
                    load_data  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized loads/stores vs a reference model.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done_valid;
    logic [31:0] load_data;
    logic        misalign;
    logic        bus_err;
    logic [31:0] dad;
    wire  [31:0] ddt;
    logic        mreq;
    logic        write_o;
    logic [1:0]  size_o;
    logic        ackd_n;

    logic        tb_ddt_en;
    logic [31:0] tb_ddt_val;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] RELEASE_PAT = 32'h5A3C_96E1;

    assign ddt = tb_ddt_en ? tb_ddt_val : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done_valid (done_valid),
        .load_data  (load_data),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .DAD        (dad),
        .DDT        (ddt),
        .MREQ       (mreq),
        .WRITE      (write_o),
        .SIZE       (size_o),
        .ACKD_n     (ackd_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction, entered just after a falling edge with the DUT idle.
    // wait_n = number of ACKD_n=1 cycles before the ack; wait_n >= TO never acks.
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wait_n, input logic [31:0] rdata);
        int          nbytes;
        logic [1:0]  exp_size;
        bit          mis;
        bit          err;
        int          n_acc;
        logic [31:0] exp_lanes;
        logic [31:0] exp_load;
        logic [31:0] piece;
        int unsigned sh;

        nbytes   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        exp_size = (nbytes == 1) ? 2'b10 : (nbytes == 2) ? 2'b01 : 2'b00;
        mis      = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
        err      = !mis && (wait_n >= int'(TO));
        n_acc    = mis ? 0 : (err ? int'(TO) : wait_n + 1);

        if (nbytes == 1)      exp_lanes = (wdata & 32'hFF) * 32'h0101_0101;
        else if (nbytes == 2) exp_lanes = (wdata & 32'hFFFF) * 32'h0001_0001;
        else                  exp_lanes = wdata;

        exp_load = 32'h0;
        if (!wr && !mis && !err) begin
            if (nbytes == 1) begin
                sh    = 8 * 32'(addr[1:0]);
                piece = (rdata >> sh) & 32'hFF;
                exp_load = (f3[2] || piece < 32'h80) ? piece : piece + 32'hFFFF_FF00;
            end else if (nbytes == 2) begin
                sh    = 16 * 32'(addr[1]);
                piece = (rdata >> sh) & 32'hFFFF;
                exp_load = (f3[2] || piece < 32'h8000) ? piece : piece + 32'hFFFF_0000;
            end else begin
                exp_load = rdata;
            end
        end

        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        check("stall_accept", 32'(stall), 32'd1);
        check("mreq_accept", 32'(mreq), 32'd0);

        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            ackd_n = (!err && i == wait_n) ? 1'b0 : 1'b1;
            if (!wr) begin
                tb_ddt_en  = 1'b1;
                tb_ddt_val = rdata;
            end
            #1;
            check("mreq_access", 32'(mreq), 32'd1);
            check("write_access", 32'(write_o), 32'(wr));
            check("size_access", 32'(size_o), 32'(exp_size));
            check("dad_access", dad, addr);
            check("stall_access", 32'(stall), 32'd1);
            check("done_in_access", 32'(done_valid), 32'd0);
            if (wr) check("ddt_store", ddt, exp_lanes);
        end

        @(negedge clk);
        ackd_n     = 1'b1;
        req_valid  = 1'b0;
        tb_ddt_en  = 1'b1;
        tb_ddt_val = RELEASE_PAT;
        #1;
        check("done_valid", 32'(done_valid), 32'd1);
        check("misalign", 32'(misalign), 32'(mis));
        check("bus_err", 32'(bus_err), 32'(err));
        check("load_data", load_data, exp_load);
        check("stall_done", 32'(stall), 32'd0);
        check("mreq_done", 32'(mreq), 32'd0);
        check("ddt_released", ddt, RELEASE_PAT);

        @(negedge clk);
        tb_ddt_en = 1'b0;
        #1;
        check("done_cleared", 32'(done_valid), 32'd0);
        check("load_cleared", load_data, 32'd0);
        check("stall_idle", 32'(stall), 32'd0);
    endtask

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [2:0]  ld_ops [5];
        logic [31:0] addr;

        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        ackd_n     = 1'b1;
        tb_ddt_en  = 1'b0;
        tb_ddt_val = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_mreq", 32'(mreq), 32'd0);
        check("rst_write", 32'(write_o), 32'd0);
        check("rst_size", 32'(size_o), 32'd0);
        check("rst_dad", dad, 32'd0);
        check("rst_done", 32'(done_valid), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_load", load_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_txn(1'b0, 3'b010, 32'h0000_2000, 32'h0, 0, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b000, 32'h0000_2003, 32'h0, 0, 32'h8012_3456);
        run_txn(1'b0, 3'b100, 32'h0000_2003, 32'h0, 1, 32'h8012_3456);
        run_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'h8001_1234);
        run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 2, 32'h8001_1234);
        run_txn(1'b1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 3, 32'h0);
        run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_C3F0, 0, 32'h0);
        run_txn(1'b1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 1, 32'h0);
        run_txn(1'b0, 3'b001, 32'h0000_2001, 32'h0, 0, 32'h0);
        run_txn(1'b1, 3'b010, 32'h0000_2006, 32'h1111_2222, 0, 32'h0);
        run_txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, int'(TO), 32'h1234_5678);
        run_txn(1'b0, 3'b010, 32'h0000_3004, 32'h0, int'(TO) - 1, 32'h8765_4321);

        // Reset in the middle of a store access drops the request
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_4000;
        req_wdata  = 32'h0BAD_CAFE;
        @(negedge clk);
        #1;
        check("rst_mid_mreq_before", 32'(mreq), 32'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        tb_ddt_en  = 1'b1;
        tb_ddt_val = RELEASE_PAT;
        #1;
        check("rst_mid_mreq", 32'(mreq), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_done", 32'(done_valid), 32'd0);
        check("rst_mid_ddt", ddt, RELEASE_PAT);
        @(negedge clk);
        tb_ddt_en = 1'b0;
        #1;
        check("rst_mid_no_done", 32'(done_valid), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = wr ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01)      addr[0] = 1'b0;
                else if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            run_txn(wr, f3, addr, $urandom, int'($urandom_range(0, 5)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
